// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port RAM between the CPU memory path and a
// DMA/program-loader port. Accesses are serialised through IDLE -> ACCESS ->
// RELEASE; the winning request is latched at the IDLE edge and the RAM lines
// are held for ACC_CYCLES cycles, followed by a one-cycle ack.
//
// Ports
//   clk, reset                       clock, synchronous active-high reset
//   cpu_req/we/addr/wdata            CPU request (held until cpu_ack)
//   cpu_rdata, cpu_ack, cpu_stall    CPU read data, completion pulse, stall
//   dma_req/we/addr/wdata/lock       DMA request, lock asks to keep grant
//   dma_rdata, dma_ack               DMA read data, completion pulse
//   ram_addr/we/oe/wdata             registered RAM controls
//   ram_rdata                        RAM read data
//   busy                             high whenever the FSM is not idle
module ram_arbiter #(
   parameter int unsigned ADDR_W     = 8,
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned ACC_CYCLES = 2,
   parameter bit          FAIR       = 1'b1,
   parameter int unsigned LOCK_MAX   = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ack,
   output logic              cpu_stall,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   input  logic              dma_lock,
   output logic [DATA_W-1:0] dma_rdata,
   output logic              dma_ack,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic              ram_oe,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              busy
);

   localparam int unsigned CNT_W  = (ACC_CYCLES > 1) ? $clog2(ACC_CYCLES) : 1;
   localparam int unsigned LOCK_W = $clog2(LOCK_MAX + 1);
   localparam logic [CNT_W-1:0]  CNT_LOAD   = CNT_W'(ACC_CYCLES - 1);
   localparam logic [LOCK_W-1:0] LOCK_LIMIT = LOCK_W'(LOCK_MAX);

   typedef enum logic [1:0] {StIdle, StAccess, StRelease} state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [LOCK_W-1:0]   lock_cnt_q, lock_cnt_d;
   logic                winner_q, winner_d;        // 1 = DMA owns the current access
   logic                last_winner_q, last_winner_d;
   logic                lock_pend_q, lock_pend_d;  // last grant was a DMA burst request
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
   logic                ram_we_q, ram_we_d;
   logic                ram_oe_q, ram_oe_d;
   logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
   logic [DATA_W-1:0]   dma_rdata_q, dma_rdata_d;
   logic                cpu_ack_q, cpu_ack_d;
   logic                dma_ack_q, dma_ack_d;

   logic                lock_ovr;
   logic                pick_dma;
   logic                pick_we;

   // Arbitration for the next IDLE edge. A pending DMA burst overrides the
   // normal choice until it has used up its LOCK_MAX consecutive grants.
   always_comb begin
      lock_ovr = lock_pend_q & dma_req & (lock_cnt_q < LOCK_LIMIT);
      pick_dma = 1'b0;
      if (lock_ovr) begin
         pick_dma = 1'b1;
      end else if (cpu_req & dma_req) begin
         pick_dma = FAIR ? ~last_winner_q : 1'b0;
      end else begin
         pick_dma = dma_req;
      end
      pick_we = pick_dma ? dma_we : cpu_we;
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      lock_cnt_d    = lock_cnt_q;
      winner_d      = winner_q;
      last_winner_d = last_winner_q;
      lock_pend_d   = lock_pend_q;
      we_d          = we_q;
      ram_addr_d    = ram_addr_q;
      ram_wdata_d   = ram_wdata_q;
      ram_we_d      = ram_we_q;
      ram_oe_d      = ram_oe_q;
      cpu_rdata_d   = cpu_rdata_q;
      dma_rdata_d   = dma_rdata_q;
      cpu_ack_d     = 1'b0;
      dma_ack_d     = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (cpu_req | dma_req) begin
               winner_d      = pick_dma;
               last_winner_d = pick_dma;
               we_d          = pick_we;
               ram_addr_d    = pick_dma ? dma_addr : cpu_addr;
               ram_wdata_d   = pick_dma ? dma_wdata : cpu_wdata;
               ram_we_d      = pick_we;
               ram_oe_d      = ~pick_we;
               cnt_d         = CNT_LOAD;
               state_d       = StAccess;
               // Only DMA grants that follow a locked release count toward the cap.
               if (pick_dma & lock_pend_q) begin
                  if (lock_cnt_q < LOCK_LIMIT) begin
                     lock_cnt_d = lock_cnt_q + 1'b1;
                  end
               end else begin
                  lock_cnt_d = '0;
               end
            end
         end
         StAccess: begin
            if (cnt_q == '0) begin
               ram_we_d = 1'b0;
               ram_oe_d = 1'b0;
               state_d  = StRelease;
               if (winner_q) begin
                  dma_ack_d = 1'b1;
                  if (!we_q) dma_rdata_d = ram_rdata;
               end else begin
                  cpu_ack_d = 1'b1;
                  if (!we_q) cpu_rdata_d = ram_rdata;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StRelease: begin
            lock_pend_d = winner_q & dma_lock;
            state_d     = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= StIdle;
         cnt_q         <= '0;
         lock_cnt_q    <= '0;
         winner_q      <= 1'b0;
         last_winner_q <= 1'b1;  // so the CPU wins the first tie
         lock_pend_q   <= 1'b0;
         we_q          <= 1'b0;
         ram_addr_q    <= '0;
         ram_wdata_q   <= '0;
         ram_we_q      <= 1'b0;
         ram_oe_q      <= 1'b0;
         cpu_rdata_q   <= '0;
         dma_rdata_q   <= '0;
         cpu_ack_q     <= 1'b0;
         dma_ack_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         lock_cnt_q    <= lock_cnt_d;
         winner_q      <= winner_d;
         last_winner_q <= last_winner_d;
         lock_pend_q   <= lock_pend_d;
         we_q          <= we_d;
         ram_addr_q    <= ram_addr_d;
         ram_wdata_q   <= ram_wdata_d;
         ram_we_q      <= ram_we_d;
         ram_oe_q      <= ram_oe_d;
         cpu_rdata_q   <= cpu_rdata_d;
         dma_rdata_q   <= dma_rdata_d;
         cpu_ack_q     <= cpu_ack_d;
         dma_ack_q     <= dma_ack_d;
      end
   end

   assign cpu_rdata = cpu_rdata_q;
   assign cpu_ack   = cpu_ack_q;
   assign cpu_stall = cpu_req & ~cpu_ack_q;
   assign dma_rdata = dma_rdata_q;
   assign dma_ack   = dma_ack_q;
   assign ram_addr  = ram_addr_q;
   assign ram_we    = ram_we_q;
   assign ram_oe    = ram_oe_q;
   assign ram_wdata = ram_wdata_q;
   assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: bench for ram_arbiter. A round-robin instance talks to a
// behavioural RAM; a fixed-priority instance reads a RAM whose data is the
// inverted address. Expected acks are queued in grant order and checked as
// they arrive.
module tb_ram_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic       cpu_req, cpu_we, dma_req, dma_we, dma_lock;
   logic [7:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
   logic [7:0] cpu_rdata, dma_rdata, ram_addr, ram_wdata, ram_rdata;
   logic       cpu_ack, cpu_stall, dma_ack, ram_we, ram_oe, busy;

   logic       f_cpu_req, f_dma_req;
   logic [7:0] f_cpu_addr, f_dma_addr;
   logic       f_zero_bit;
   logic [7:0] f_zero_byte;
   logic [7:0] f_cpu_rdata, f_dma_rdata, f_ram_addr, f_ram_wdata, f_ram_rdata;
   logic       f_cpu_ack, f_cpu_stall, f_dma_ack, f_ram_we, f_ram_oe, f_busy;

   logic [7:0] mem [256];

   int total = 0;
   int passed = 0;

   typedef struct {bit port; bit rd; logic [7:0] data;} exp_t;
   typedef struct {bit port; bit we; logic [7:0] addr; logic [7:0] wdata; logic [7:0] rdata;} vec_t;

   exp_t sbq[$];
   exp_t fq[$];

   always #5 clk = ~clk;

   ram_arbiter u_dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_lock(dma_lock), .dma_rdata(dma_rdata), .dma_ack(dma_ack),
      .ram_addr(ram_addr), .ram_we(ram_we), .ram_oe(ram_oe), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .busy(busy)
   );

   ram_arbiter #(.FAIR(1'b0)) u_dut_fixed (
      .clk(clk), .reset(reset),
      .cpu_req(f_cpu_req), .cpu_we(f_zero_bit), .cpu_addr(f_cpu_addr),
      .cpu_wdata(f_zero_byte), .cpu_rdata(f_cpu_rdata), .cpu_ack(f_cpu_ack),
      .cpu_stall(f_cpu_stall),
      .dma_req(f_dma_req), .dma_we(f_zero_bit), .dma_addr(f_dma_addr),
      .dma_wdata(f_zero_byte), .dma_lock(f_zero_bit), .dma_rdata(f_dma_rdata),
      .dma_ack(f_dma_ack),
      .ram_addr(f_ram_addr), .ram_we(f_ram_we), .ram_oe(f_ram_oe), .ram_wdata(f_ram_wdata),
      .ram_rdata(f_ram_rdata), .busy(f_busy)
   );

   always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_wdata;
   assign ram_rdata   = mem[ram_addr];
   assign f_ram_rdata = ~f_ram_addr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Scoreboard for the round-robin instance.
   always @(negedge clk) begin : mon
      exp_t e;
      if (!reset) begin
         if (ram_we) chk("ram_we_only_in_access", 32'(busy), 1);
         if (cpu_ack || dma_ack) begin
            chk("single_ack", 32'(cpu_ack & dma_ack), 0);
            total++;
            if (sbq.size() == 0) begin
               $display("FAIL unexpected_ack: got cpu_ack=%0b dma_ack=%0b, expected none",
                        cpu_ack, dma_ack);
            end else begin
               passed++;
               e = sbq.pop_front();
               chk("ack_port", 32'(dma_ack), 32'(e.port));
               if (e.rd) chk("ack_rdata", 32'(e.port ? dma_rdata : cpu_rdata), 32'(e.data));
            end
         end
      end
   end

   // Scoreboard for the fixed-priority instance.
   always @(negedge clk) begin : fmon
      exp_t e;
      if (!reset && (f_cpu_ack || f_dma_ack)) begin
         total++;
         if (fq.size() == 0) begin
            $display("FAIL fixed_unexpected_ack: got cpu_ack=%0b dma_ack=%0b, expected none",
                     f_cpu_ack, f_dma_ack);
         end else begin
            passed++;
            e = fq.pop_front();
            chk("fixed_ack_port", 32'(f_dma_ack), 32'(e.port));
            chk("fixed_rdata", 32'(e.port ? f_dma_rdata : f_cpu_rdata), 32'(e.data));
         end
      end
   end

   function automatic logic get_ack(input int port);
      case (port)
         0: return cpu_ack;
         1: return dma_ack;
         2: return f_cpu_ack;
         default: return f_dma_ack;
      endcase
   endfunction

   task automatic set_req(input int port, input logic req, input logic we,
                          input logic [7:0] addr, input logic [7:0] wdata);
      case (port)
         0: begin cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; end
         1: begin dma_req = req; dma_we = we; dma_addr = addr; dma_wdata = wdata; end
         2: begin f_cpu_req = req; f_cpu_addr = addr; end
         default: begin f_dma_req = req; f_dma_addr = addr; end
      endcase
   endtask

   // Back-to-back accesses from one port, address/data stepping from base;
   // req stays high between accesses. Call at a negedge.
   task automatic run_port(input int port, input int n, input logic we,
                           input logic [7:0] base, input logic [7:0] dbase);
      int t;
      for (int i = 0; i < n; i++) begin
         set_req(port, 1'b1, we, 8'(base + i), 8'(dbase + i));
         t = 0;
         do begin
            @(negedge clk);
            t++;
         end while (!get_ack(port) && t < 200);
         if (!get_ack(port)) begin
            $display("FAIL ack_timeout: port %0d got no ack within %0d cycles, expected ack",
                     port, t);
            total++;
            i = n;
         end
      end
      set_req(port, 1'b0, 1'b0, 8'h00, 8'h00);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[10];
      int   t;

      vecs[0] = '{0, 1, 8'h20, 8'h3C, 8'h00};
      vecs[1] = '{1, 0, 8'h20, 8'h00, 8'h3C};
      vecs[2] = '{1, 1, 8'hFF, 8'h5A, 8'h00};
      vecs[3] = '{0, 0, 8'hFF, 8'h00, 8'h5A};
      vecs[4] = '{1, 1, 8'h00, 8'h11, 8'h00};
      vecs[5] = '{0, 0, 8'h00, 8'h00, 8'h11};
      vecs[6] = '{0, 1, 8'h21, 8'h96, 8'h00};
      vecs[7] = '{1, 0, 8'h21, 8'h00, 8'h96};
      vecs[8] = '{1, 1, 8'h10, 8'hC3, 8'h00};
      vecs[9] = '{0, 0, 8'h10, 8'h00, 8'hC3};

      set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
      set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
      set_req(2, 1'b0, 1'b0, 8'h00, 8'h00);
      set_req(3, 1'b0, 1'b0, 8'h00, 8'h00);
      dma_lock    = 1'b0;
      f_zero_bit  = 1'b0;
      f_zero_byte = 8'h00;
      @(negedge clk);
      do_reset();

      // Reset state
      chk("rst_busy", 32'(busy), 0);
      chk("rst_cpu_ack", 32'(cpu_ack), 0);
      chk("rst_dma_ack", 32'(dma_ack), 0);
      chk("rst_cpu_rdata", 32'(cpu_rdata), 0);
      chk("rst_dma_rdata", 32'(dma_rdata), 0);
      chk("rst_ram_addr", 32'(ram_addr), 0);
      chk("rst_ram_we", 32'(ram_we), 0);
      chk("rst_ram_oe", 32'(ram_oe), 0);
      chk("rst_ram_wdata", 32'(ram_wdata), 0);
      chk("rst_cpu_stall", 32'(cpu_stall), 0);
      chk("rst_fixed_busy", 32'(f_busy), 0);

      // CPU write 0x10=0xA5: ram_we for exactly two cycles, ack on the third
      sbq.push_back('{0, 0, 8'h00});
      set_req(0, 1'b1, 1'b1, 8'h10, 8'hA5);
      @(negedge clk);
      chk("t1_we_c1", 32'(ram_we), 1);
      chk("t1_oe_c1", 32'(ram_oe), 0);
      chk("t1_addr", 32'(ram_addr), 32'h10);
      chk("t1_wdata", 32'(ram_wdata), 32'hA5);
      chk("t1_busy", 32'(busy), 1);
      chk("t1_stall", 32'(cpu_stall), 1);
      @(negedge clk);
      chk("t1_we_c2", 32'(ram_we), 1);
      chk("t1_ack_early", 32'(cpu_ack), 0);
      @(negedge clk);
      chk("t1_we_c3", 32'(ram_we), 0);
      chk("t1_ack", 32'(cpu_ack), 1);
      chk("t1_stall_ack", 32'(cpu_stall), 0);
      set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
      @(negedge clk);
      chk("t1_ack_pulse", 32'(cpu_ack), 0);
      chk("t1_idle", 32'(busy), 0);
      sbq.push_back('{1, 1, 8'hA5});
      run_port(1, 1, 1'b0, 8'h10, 8'h00);
      @(negedge clk);

      // Single-port vectors
      for (int i = 0; i < 10; i++) begin
         sbq.push_back('{vecs[i].port, !vecs[i].we, vecs[i].rdata});
         run_port(int'(vecs[i].port), 1, vecs[i].we, vecs[i].addr, vecs[i].wdata);
         @(negedge clk);
      end

      // Held CPU read at 0xFF: stall every cycle until ack, data held afterwards
      sbq.push_back('{0, 1, 8'h5A});
      set_req(0, 1'b1, 1'b0, 8'hFF, 8'h00);
      t = 0;
      do begin
         @(negedge clk);
         t++;
         if (t == 1) chk("t5_oe", 32'(ram_oe), 1);
         if (!cpu_ack) chk("t5_stall", 32'(cpu_stall), 1);
      end while (!cpu_ack && t < 20);
      chk("t5_ack", 32'(cpu_ack), 1);
      chk("t5_stall_ack", 32'(cpu_stall), 0);
      set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
      repeat (3) @(negedge clk);
      chk("t5_rdata_held", 32'(cpu_rdata), 32'h5A);

      // Request held through RELEASE: no access there, next starts at the IDLE edge
      sbq.push_back('{0, 1, 8'h11});
      sbq.push_back('{0, 1, 8'h11});
      set_req(0, 1'b1, 1'b0, 8'h00, 8'h00);
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!cpu_ack && t < 20);
      chk("t6_first_ack", 32'(cpu_ack), 1);
      @(negedge clk);
      chk("t6_idle_busy", 32'(busy), 0);
      chk("t6_idle_oe", 32'(ram_oe), 0);
      chk("t6_no_dup_ack", 32'(cpu_ack), 0);
      @(negedge clk);
      chk("t6_restart_busy", 32'(busy), 1);
      chk("t6_restart_oe", 32'(ram_oe), 1);
      set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);  // dropped mid-access, must still ack
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!cpu_ack && t < 20);
      chk("t6_second_ack", 32'(cpu_ack), 1);
      @(negedge clk);

      // Simultaneous requests after reset, round-robin: C D C D
      do_reset();
      sbq.push_back('{0, 1, 8'h5A});
      sbq.push_back('{1, 1, 8'h3C});
      sbq.push_back('{0, 1, 8'h11});
      sbq.push_back('{1, 1, 8'h96});
      fork
         run_port(0, 2, 1'b0, 8'hFF, 8'h00);
         run_port(1, 2, 1'b0, 8'h20, 8'h00);
      join
      @(negedge clk);
      chk("t2_rr_drained", 32'(sbq.size()), 0);

      // Fixed priority: CPU keeps winning until it drops
      do_reset();
      fq.push_back('{0, 1, 8'hFA});
      fq.push_back('{0, 1, 8'hF9});
      fq.push_back('{0, 1, 8'hF8});
      fq.push_back('{1, 1, 8'hF6});
      fork
         run_port(2, 3, 1'b0, 8'h05, 8'h00);
         run_port(3, 1, 1'b0, 8'h09, 8'h00);
      join
      @(negedge clk);
      chk("t2_fixed_drained", 32'(fq.size()), 0);

      // Locked DMA burst of 10 with CPU waiting: 5 DMA, CPU, 5 DMA
      do_reset();
      for (int i = 0; i < 5; i++) sbq.push_back('{1, 0, 8'h00});
      sbq.push_back('{0, 1, 8'h80});
      for (int i = 0; i < 5; i++) sbq.push_back('{1, 0, 8'h00});
      dma_lock = 1'b1;
      fork
         run_port(1, 10, 1'b1, 8'h40, 8'h80);
         begin
            @(negedge clk);
            run_port(0, 1, 1'b0, 8'h40, 8'h00);
         end
      join
      dma_lock = 1'b0;
      @(negedge clk);
      chk("t3_lock_drained", 32'(sbq.size()), 0);
      chk("t3_cpu_rdata", 32'(cpu_rdata), 32'h80);

      // Reset in the second ACCESS cycle of a CPU write
      set_req(0, 1'b1, 1'b1, 8'h30, 8'h77);
      @(negedge clk);
      chk("t4_we_c1", 32'(ram_we), 1);
      @(negedge clk);
      chk("t4_we_c2", 32'(ram_we), 1);
      reset = 1'b1;
      set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
      @(negedge clk);
      chk("t4_we_after", 32'(ram_we), 0);
      chk("t4_ack_after", 32'(cpu_ack), 0);
      chk("t4_busy_after", 32'(busy), 0);
      chk("t4_rdata_after", 32'(cpu_rdata), 0);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t4_no_ack", 32'(cpu_ack), 0);
      end

      chk("final_drained", 32'(sbq.size()), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
